// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store initiator: op and FSM encodings,
// RAM control constants, request record and small op-decoding helpers.
package mem_access_ctrl_pkg;

  // RAM control constants
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        ChipEnable   = 1'b1;
  localparam logic        ChipDisable  = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // Load/store op encodings as presented by the MEM stage
  localparam logic [2:0] MEM_OP_LB  = 3'd0;
  localparam logic [2:0] MEM_OP_LBU = 3'd1;
  localparam logic [2:0] MEM_OP_LH  = 3'd2;
  localparam logic [2:0] MEM_OP_LHU = 3'd3;
  localparam logic [2:0] MEM_OP_LW  = 3'd4;
  localparam logic [2:0] MEM_OP_SB  = 3'd5;
  localparam logic [2:0] MEM_OP_SH  = 3'd6;
  localparam logic [2:0] MEM_OP_SW  = 3'd7;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Request as latched from the MEM stage
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic mem_size_e op_size(input logic [2:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return SZ_BYTE;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return SZ_HALF;
      default:                          return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_store(input logic [2:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a big-endian 32-bit RAM (byte 0 on bits [31:24]).
// Produces the lane select, replicated store data and the extended load
// value for one op/offset pair. Purely combinational.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  sel,
  output logic [31:0] sdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte/halfword out of the RAM word
  always_comb begin
    rbyte = rword[7:0];
    case (a)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    // a[0] is don't-care for halfwords: aligned halves only
    rhalf = a[1] ? rword[15:0] : rword[31:16];
  end

  // Lane select, store replication and load extension by access size
  always_comb begin
    sel   = 4'b0000;
    sdata = ZeroWord;
    ldata = ZeroWord;
    case (op_size(op))
      SZ_BYTE: begin
        sel   = 4'b1000 >> a;
        sdata = {4{wdata[7:0]}};
        ldata = op_signed(op) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      SZ_HALF: begin
        sel   = a[1] ? 4'b0011 : 4'b1100;
        sdata = {2{wdata[15:0]}};
        ldata = op_signed(op) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      end
      default: begin
        sel   = 4'b1111;
        sdata = wdata;
        ldata = rword;
      end
    endcase
    // Stores return nothing on the read path
    if (op_store(op)) ldata = ZeroWord;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and the byte-banked data RAM.
// Latches one request, holds the RAM port active for ACCESS_LAT cycles,
// then pulses done_o with the extended load result.
// Optional: define ALIGN_CHECK_EN to add misalign_o; misaligned halfword or
// word requests then skip the RAM and complete at once with misalign_o=1.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ACCESS_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_req_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
`ifdef ALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(ACCESS_LAT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  mem_req_t         rq;
  logic [31:0]      rdata_q;
  logic [3:0]       sel;
  logic [31:0]      sdata;
  logic [31:0]      ldata;
  logic             access;

  mem_lane_align u_align (
    .op    (rq.op),
    .a     (rq.addr[1:0]),
    .wdata (rq.wdata),
    .rword (mem_data_i),
    .sel   (sel),
    .sdata (sdata),
    .ldata (ldata)
  );

`ifdef ALIGN_CHECK_EN
  logic mis_in;
  logic mis_q;

  // Flag an incoming halfword on an odd byte or a word off a word boundary
  always_comb begin
    mis_in = 1'b0;
    case (op_size(op_i))
      SZ_HALF: mis_in = addr_i[0];
      SZ_WORD: mis_in = (addr_i[1:0] != 2'b00);
      default: mis_in = 1'b0;
    endcase
  end

  assign misalign_o = (state == ST_RESP) && mis_q;
`endif

  // Request FSM: latch in IDLE, run the RAM port in ACCESS, report in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rq      <= '0;
      rdata_q <= ZeroWord;
`ifdef ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            rq      <= '{op: op_i, addr: addr_i, wdata: wdata_i};
            rdata_q <= ZeroWord;
`ifdef ALIGN_CHECK_EN
            mis_q   <= mis_in;
            if (mis_in) begin
              state <= ST_RESP;
            end else begin
              state <= ST_ACCESS;
              cnt   <= CNT_W'(1);
            end
`else
            state   <= ST_ACCESS;
            cnt     <= CNT_W'(1);
`endif
          end
        end
        ST_ACCESS: begin
          if (cnt == LAT) begin
            rdata_q <= ldata;
            cnt     <= '0;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A request still held here is the one just completed; ignore it
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign access      = (state == ST_ACCESS);
  assign stall_req_o = (state == ST_IDLE) ? req_i : access;
  assign done_o      = (state == ST_RESP);
  assign rdata_o     = done_o ? rdata_q : ZeroWord;

  assign mem_ce_o   = access ? ChipEnable : ChipDisable;
  assign mem_we_o   = (access && op_store(rq.op)) ? WriteEnable : WriteDisable;
  assign mem_sel_o  = access ? sel : 4'b0000;
  assign mem_addr_o = access ? {rq.addr[31:2], 2'b00} : ZeroWord;
  assign mem_data_o = access ? sdata : ZeroWord;

endmodule
